// File: rtl/regfile_write_arbiter_if.sv
// Bus between the writeback stage, the coprocessor request port and the register-file
// write port. The master side drives requests; the arbiter sits on the slave side.
interface regfile_write_arbiter_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;

  logic              cp_req_valid;
  logic              cp_req_ready;
  logic [ADDR_W-1:0] cp_req_reg;
  logic [DATA_W-1:0] cp_req_data;

  logic              ctrl_writeEnable;
  logic [ADDR_W-1:0] ctrl_writeReg;
  logic [DATA_W-1:0] data_writeReg;
  logic [CNT_W-1:0]  fifo_count;
  logic              forced_slot;

  modport master (
    output wb_valid, wb_reg, wb_data,
    output cp_req_valid, cp_req_reg, cp_req_data,
    input  wb_ready, cp_req_ready,
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, fifo_count, forced_slot
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data,
    input  cp_req_valid, cp_req_reg, cp_req_data,
    output wb_ready, cp_req_ready,
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg, fifo_count, forced_slot
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port: writeback has priority, coprocessor writes queue in a
// FIFO and drain in idle slots, with a starvation counter that forces a coprocessor slot.
module regfile_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  regfile_write_arbiter_if.slave bus
);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int ENTRY_W  = ADDR_W + DATA_W;

  logic [ENTRY_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                en_q, en_d;
  logic [ADDR_W-1:0]   reg_q, reg_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                forced_q, forced_d;

  logic               fifo_empty, fifo_full, forced, grant_wb, grant_cp, push, pop;
  logic [ENTRY_W-1:0] head;

  always_comb begin
    head       = mem_q[rd_ptr_q];
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    forced     = (starve_q == STARVE_W'(STARVE_LIMIT)) && !fifo_empty;
    grant_wb   = bus.wb_valid && !forced;
    grant_cp   = !fifo_empty && !grant_wb;
    // Full blocks pushes even when a pop happens in the same cycle.
    push       = bus.cp_req_valid && !fifo_full;
    pop        = grant_cp;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    en_d     = 1'b0;
    reg_d    = reg_q;
    data_d   = data_q;
    forced_d = forced;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    if (pop || fifo_empty)
      starve_d = '0;
    else if (grant_wb && (starve_q != STARVE_W'(STARVE_LIMIT)))
      starve_d = starve_q + STARVE_W'(1);

    // Register 0 is consumed like any other slot but never enabled at the port.
    if (grant_wb) begin
      reg_d  = bus.wb_reg;
      data_d = bus.wb_data;
      en_d   = (bus.wb_reg != '0);
    end else if (grant_cp) begin
      reg_d  = head[ENTRY_W-1:DATA_W];
      data_d = head[DATA_W-1:0];
      en_d   = (head[ENTRY_W-1:DATA_W] != '0);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {bus.cp_req_reg, bus.cp_req_data};
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      en_q     <= 1'b0;
      reg_q    <= '0;
      data_q   <= '0;
      forced_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      en_q     <= en_d;
      reg_q    <= reg_d;
      data_q   <= data_d;
      forced_q <= forced_d;
    end
  end

  assign bus.wb_ready         = !forced;
  assign bus.cp_req_ready     = !fifo_full;
  assign bus.ctrl_writeEnable = en_q;
  assign bus.ctrl_writeReg    = reg_q;
  assign bus.data_writeReg    = data_q;
  assign bus.fifo_count       = count_q;
  assign bus.forced_slot      = forced_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: each scenario task drives vectors and checks
// hand-computed results one cycle at a time.
module tb_regfile_write_arbiter;
  logic clock = 1'b0;
  logic ctrl_reset_n = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;

  regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4)) bus ();

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clock       (clock),
    .ctrl_reset_n(ctrl_reset_n),
    .bus         (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    bus.wb_valid = 1'b0;
    bus.wb_reg = '0;
    bus.wb_data = '0;
    bus.cp_req_valid = 1'b0;
    bus.cp_req_reg = '0;
    bus.cp_req_data = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    ctrl_reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 ctrl_reset_n = 1'b1;
    tick();
    $display("[TB] reset released");
    tests_run++; if (bus.ctrl_writeEnable !== 1'b0) begin tests_failed++; $display("FAIL reset_en: got %b expected 0", bus.ctrl_writeEnable); end
    tests_run++; if (bus.ctrl_writeReg !== 5'd0) begin tests_failed++; $display("FAIL reset_reg: got %0d expected 0", bus.ctrl_writeReg); end
    tests_run++; if (bus.data_writeReg !== 32'd0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", bus.data_writeReg); end
    tests_run++; if (bus.fifo_count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", bus.fifo_count); end
    tests_run++; if (bus.forced_slot !== 1'b0) begin tests_failed++; $display("FAIL reset_forced: got %b expected 0", bus.forced_slot); end
    tests_run++; if (bus.cp_req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cp_ready: got %b expected 1", bus.cp_req_ready); end
    tests_run++; if (bus.wb_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_wb_ready: got %b expected 1", bus.wb_ready); end
  endtask

  task automatic test_wb_write;
    bus.wb_valid = 1'b1;
    bus.wb_reg = 5'd5;
    bus.wb_data = 32'hDEADBEEF;
    #1;
    tests_run++; if (bus.wb_ready !== 1'b1) begin tests_failed++; $display("FAIL wb_ready: got %b expected 1", bus.wb_ready); end
    tick();
    bus.wb_valid = 1'b0;
    $display("[TB] wb write reg=5 data=deadbeef");
    tests_run++; if (bus.ctrl_writeEnable !== 1'b1) begin tests_failed++; $display("FAIL wb_en: got %b expected 1", bus.ctrl_writeEnable); end
    tests_run++; if (bus.ctrl_writeReg !== 5'd5) begin tests_failed++; $display("FAIL wb_reg: got %0d expected 5", bus.ctrl_writeReg); end
    tests_run++; if (bus.data_writeReg !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL wb_data: got %h expected deadbeef", bus.data_writeReg); end
    tick();
    tests_run++; if (bus.ctrl_writeEnable !== 1'b0) begin tests_failed++; $display("FAIL wb_idle_en: got %b expected 0", bus.ctrl_writeEnable); end
    tests_run++; if (bus.ctrl_writeReg !== 5'd5) begin tests_failed++; $display("FAIL wb_idle_hold: got %0d expected 5", bus.ctrl_writeReg); end
  endtask

  task automatic test_cp_reg0;
    bus.cp_req_valid = 1'b1;
    bus.cp_req_reg = 5'd0;
    bus.cp_req_data = 32'h1234;
    #1;
    tests_run++; if (bus.cp_req_ready !== 1'b1) begin tests_failed++; $display("FAIL reg0_ready: got %b expected 1", bus.cp_req_ready); end
    tick();
    bus.cp_req_valid = 1'b0;
    tests_run++; if (bus.fifo_count !== 3'd1) begin tests_failed++; $display("FAIL reg0_count_push: got %0d expected 1", bus.fifo_count); end
    tests_run++; if (bus.ctrl_writeEnable !== 1'b0) begin tests_failed++; $display("FAIL reg0_no_bypass: got %b expected 0", bus.ctrl_writeEnable); end
    tick();
    $display("[TB] cp write reg=0 data=00001234");
    tests_run++; if (bus.ctrl_writeEnable !== 1'b0) begin tests_failed++; $display("FAIL reg0_en: got %b expected 0", bus.ctrl_writeEnable); end
    tests_run++; if (bus.ctrl_writeReg !== 5'd0) begin tests_failed++; $display("FAIL reg0_reg: got %0d expected 0", bus.ctrl_writeReg); end
    tests_run++; if (bus.data_writeReg !== 32'h1234) begin tests_failed++; $display("FAIL reg0_data: got %h expected 00001234", bus.data_writeReg); end
    tests_run++; if (bus.fifo_count !== 3'd0) begin tests_failed++; $display("FAIL reg0_count_pop: got %0d expected 0", bus.fifo_count); end
  endtask

  task automatic test_starvation;
    bus.wb_valid = 1'b1;
    bus.wb_reg = 5'd3;
    bus.wb_data = 32'hA5A50003;
    for (int i = 0; i < 4; i++) begin
      bus.cp_req_valid = 1'b1;
      bus.cp_req_reg = 5'(26 + i);
      bus.cp_req_data = 32'(i + 1);
      #1;
      tests_run++; if (bus.cp_req_ready !== 1'b1) begin tests_failed++; $display("FAIL starve_push_ready[%0d]: got %b expected 1", i, bus.cp_req_ready); end
      tick();
      $display("[TB] cp push reg=%0d data=%0d", 26 + i, i + 1);
    end
    bus.cp_req_valid = 1'b0;
    #1;
    tests_run++; if (bus.cp_req_ready !== 1'b0) begin tests_failed++; $display("FAIL starve_full_ready: got %b expected 0", bus.cp_req_ready); end
    tests_run++; if (bus.fifo_count !== 3'd4) begin tests_failed++; $display("FAIL starve_full_count: got %0d expected 4", bus.fifo_count); end
    for (int i = 0; i < 5; i++) begin
      tests_run++; if (bus.wb_ready !== 1'b1) begin tests_failed++; $display("FAIL starve_win1[%0d]: got %b expected 1", i, bus.wb_ready); end
      tick();
    end
    tests_run++; if (bus.wb_ready !== 1'b0) begin tests_failed++; $display("FAIL starve_force1: got %b expected 0", bus.wb_ready); end
    tick();
    $display("[TB] forced write reg=%0d data=%0d", bus.ctrl_writeReg, bus.data_writeReg);
    tests_run++; if (bus.ctrl_writeEnable !== 1'b1) begin tests_failed++; $display("FAIL force1_en: got %b expected 1", bus.ctrl_writeEnable); end
    tests_run++; if (bus.ctrl_writeReg !== 5'd26) begin tests_failed++; $display("FAIL force1_reg: got %0d expected 26", bus.ctrl_writeReg); end
    tests_run++; if (bus.data_writeReg !== 32'd1) begin tests_failed++; $display("FAIL force1_data: got %h expected 1", bus.data_writeReg); end
    tests_run++; if (bus.forced_slot !== 1'b1) begin tests_failed++; $display("FAIL force1_pulse: got %b expected 1", bus.forced_slot); end
    tests_run++; if (bus.fifo_count !== 3'd3) begin tests_failed++; $display("FAIL force1_count: got %0d expected 3", bus.fifo_count); end
    for (int i = 0; i < 8; i++) begin
      tests_run++; if (bus.wb_ready !== 1'b1) begin tests_failed++; $display("FAIL starve_win2[%0d]: got %b expected 1", i, bus.wb_ready); end
      tick();
      if (i == 0) begin
        tests_run++; if (bus.forced_slot !== 1'b0) begin tests_failed++; $display("FAIL force1_pulse_end: got %b expected 0", bus.forced_slot); end
        tests_run++; if (bus.ctrl_writeReg !== 5'd3) begin tests_failed++; $display("FAIL wb_after_force: got %0d expected 3", bus.ctrl_writeReg); end
      end
    end
    tests_run++; if (bus.wb_ready !== 1'b0) begin tests_failed++; $display("FAIL starve_force2: got %b expected 0", bus.wb_ready); end
    tick();
    bus.wb_valid = 1'b0;
    $display("[TB] forced write reg=%0d data=%0d", bus.ctrl_writeReg, bus.data_writeReg);
    tests_run++; if (bus.ctrl_writeReg !== 5'd27) begin tests_failed++; $display("FAIL force2_reg: got %0d expected 27", bus.ctrl_writeReg); end
    tests_run++; if (bus.data_writeReg !== 32'd2) begin tests_failed++; $display("FAIL force2_data: got %h expected 2", bus.data_writeReg); end
    tests_run++; if (bus.forced_slot !== 1'b1) begin tests_failed++; $display("FAIL force2_pulse: got %b expected 1", bus.forced_slot); end
    tick();
    tests_run++; if (bus.ctrl_writeReg !== 5'd28) begin tests_failed++; $display("FAIL drain_reg28: got %0d expected 28", bus.ctrl_writeReg); end
    tests_run++; if (bus.forced_slot !== 1'b0) begin tests_failed++; $display("FAIL drain_pulse: got %b expected 0", bus.forced_slot); end
    tick();
    tests_run++; if (bus.ctrl_writeReg !== 5'd29 || bus.data_writeReg !== 32'd4) begin tests_failed++; $display("FAIL drain_reg29: got %0d/%h expected 29/4", bus.ctrl_writeReg, bus.data_writeReg); end
    tests_run++; if (bus.fifo_count !== 3'd0) begin tests_failed++; $display("FAIL drain_count: got %0d expected 0", bus.fifo_count); end
  endtask

  task automatic test_full_pop;
    bus.wb_valid = 1'b1;
    bus.wb_reg = 5'd1;
    bus.wb_data = 32'h11;
    for (int i = 0; i < 4; i++) begin
      bus.cp_req_valid = 1'b1;
      bus.cp_req_reg = 5'(16 + i);
      bus.cp_req_data = 32'(16 + i);
      tick();
    end
    bus.wb_valid = 1'b0;
    bus.cp_req_reg = 5'd20;
    bus.cp_req_data = 32'hBAD;
    #1;
    tests_run++; if (bus.cp_req_ready !== 1'b0) begin tests_failed++; $display("FAIL fullpop_ready: got %b expected 0", bus.cp_req_ready); end
    tick();
    tests_run++; if (bus.fifo_count !== 3'd3) begin tests_failed++; $display("FAIL fullpop_count: got %0d expected 3", bus.fifo_count); end
    tests_run++; if (bus.ctrl_writeReg !== 5'd16) begin tests_failed++; $display("FAIL fullpop_reg16: got %0d expected 16", bus.ctrl_writeReg); end
    bus.cp_req_data = 32'h20;
    #1;
    tests_run++; if (bus.cp_req_ready !== 1'b1) begin tests_failed++; $display("FAIL retry_ready: got %b expected 1", bus.cp_req_ready); end
    tick();
    bus.cp_req_valid = 1'b0;
    tests_run++; if (bus.fifo_count !== 3'd3) begin tests_failed++; $display("FAIL retry_count: got %0d expected 3", bus.fifo_count); end
    tests_run++; if (bus.ctrl_writeReg !== 5'd17) begin tests_failed++; $display("FAIL retry_reg17: got %0d expected 17", bus.ctrl_writeReg); end
    tick();
    tests_run++; if (bus.ctrl_writeReg !== 5'd18) begin tests_failed++; $display("FAIL fullpop_reg18: got %0d expected 18", bus.ctrl_writeReg); end
    tick();
    tests_run++; if (bus.ctrl_writeReg !== 5'd19) begin tests_failed++; $display("FAIL fullpop_reg19: got %0d expected 19", bus.ctrl_writeReg); end
    tick();
    $display("[TB] retried write reg=%0d data=%h", bus.ctrl_writeReg, bus.data_writeReg);
    tests_run++; if (bus.ctrl_writeReg !== 5'd20 || bus.data_writeReg !== 32'h20) begin tests_failed++; $display("FAIL retry_reg20: got %0d/%h expected 20/20", bus.ctrl_writeReg, bus.data_writeReg); end
    tests_run++; if (bus.fifo_count !== 3'd0) begin tests_failed++; $display("FAIL fullpop_empty: got %0d expected 0", bus.fifo_count); end
  endtask

  task automatic test_push_pop_order;
    bus.wb_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.cp_req_valid = (i < 3);
      bus.cp_req_reg = 5'(10 + i);
      bus.cp_req_data = 32'(10 + i);
      tick();
      tests_run++; if (bus.fifo_count !== ((i < 3) ? 3'd1 : 3'd0)) begin tests_failed++; $display("FAIL order_count[%0d]: got %0d expected %0d", i, bus.fifo_count, (i < 3) ? 1 : 0); end
      if (i > 0) begin
        $display("[TB] ordered write reg=%0d", bus.ctrl_writeReg);
        tests_run++; if (bus.ctrl_writeReg !== 5'(9 + i) || bus.ctrl_writeEnable !== 1'b1) begin tests_failed++; $display("FAIL order_reg[%0d]: got %0d en %b expected %0d en 1", i, bus.ctrl_writeReg, bus.ctrl_writeEnable, 9 + i); end
      end
    end
  endtask

  task automatic test_reset_mid;
    bus.wb_valid = 1'b1;
    bus.wb_reg = 5'd6;
    bus.wb_data = 32'h66;
    for (int i = 0; i < 3; i++) begin
      bus.cp_req_valid = 1'b1;
      bus.cp_req_reg = 5'(7 + i);
      bus.cp_req_data = 32'(7 + i);
      tick();
    end
    bus.cp_req_valid = 1'b0;
    tests_run++; if (bus.ctrl_writeEnable !== 1'b1 || bus.fifo_count !== 3'd3) begin tests_failed++; $display("FAIL pre_reset: got en %b count %0d expected en 1 count 3", bus.ctrl_writeEnable, bus.fifo_count); end
    ctrl_reset_n = 1'b0;
    #1;
    $display("[TB] reset asserted mid-operation");
    tests_run++; if (bus.ctrl_writeEnable !== 1'b0) begin tests_failed++; $display("FAIL async_en: got %b expected 0", bus.ctrl_writeEnable); end
    tests_run++; if (bus.ctrl_writeReg !== 5'd0 || bus.data_writeReg !== 32'd0) begin tests_failed++; $display("FAIL async_regdata: got %0d/%h expected 0/0", bus.ctrl_writeReg, bus.data_writeReg); end
    tests_run++; if (bus.fifo_count !== 3'd0) begin tests_failed++; $display("FAIL async_count: got %0d expected 0", bus.fifo_count); end
    bus.wb_valid = 1'b0;
    repeat (2) tick();
    ctrl_reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++; if (bus.ctrl_writeEnable !== 1'b0) begin tests_failed++; $display("FAIL post_reset_en[%0d]: got %b expected 0", i, bus.ctrl_writeEnable); end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_wb_write();
    test_cp_reg0();
    test_starvation();
    test_full_pop();
    test_push_pop_order();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between the pipeline writeback stage and the boid coprocessor. Writeback has priority; coprocessor writes are buffered in a small FIFO and drained in idle writeback slots, with a starvation limit that forces a coprocessor slot by back-pressuring writeback. The block's registered outputs drive the register file's write-enable, write-address and write-data inputs directly.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register index width
- FIFO_DEPTH, 4, coprocessor request buffer entries (power of 2, ≥2)
- STARVE_LIMIT, 8, consecutive writeback wins tolerated while the FIFO is non-empty
- clock  in  1  single clock; all state updates on the rising edge
- ctrl_reset_n  in  1  reset, asynchronous and active-low
- wb_valid  in  1  writeback has a write this cycle
- wb_ready  out  1  writeback write accepted this cycle (combinational)
- wb_reg  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback data
- cp_req_valid  in  1  coprocessor write request
- cp_req_ready  out  1  FIFO can accept (combinational: count < FIFO_DEPTH)
- cp_req_reg  in  ADDR_W  coprocessor destination
- cp_req_data  in  DATA_W  coprocessor data
- ctrl_writeEnable  out  1  register-file write enable (registered)
- ctrl_writeReg  out  ADDR_W  register-file write index (registered)
- data_writeReg  out  DATA_W  register-file write data (registered)
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- forced_slot  out  1  pulse, registered: the previous grant was a starvation-forced coprocessor slot

## Operation
- FIFO: push on cp_req_valid & cp_req_ready. Pop when the head is granted. Push and pop in the same cycle leave the count unchanged. No bypass: an entry is first grantable the cycle after its push.
- Grant decision per cycle, in priority order:
  - starve_cnt == STARVE_LIMIT and FIFO non-empty: grant the FIFO head, wb_ready = 0.
  - wb_valid: grant writeback, wb_ready = 1.
  - FIFO non-empty: grant the FIFO head.
  - Otherwise: no grant.
- wb_ready = 1 whenever it is not forced low by the starvation rule, including when wb_valid = 0.
- starve_cnt, width $clog2(STARVE_LIMIT+1):
  - Increments when writeback is granted and the FIFO is non-empty.
  - Clears on any FIFO pop.
  - Clears whenever the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Register-0 writes are granted and consumed (popped or accepted) normally, but the registered ctrl_writeEnable is 0 for that slot. ctrl_writeReg and data_writeReg still carry the values.
- Output register loads the granted {reg, data} and enable every cycle. With no grant: enable = 0, and reg/data hold their previous values.
- Reset (asynchronous assert, synchronous-safe deassert by the system) clears:
  - FIFO pointers and count (contents are don't-care)
  - starve_cnt
  - ctrl_writeEnable = 0, ctrl_writeReg = 0, data_writeReg = 0, forced_slot = 0
- Reset mid-operation discards buffered and in-flight writes; no partial write is issued after reset.

## Timing
- Writeback accepted in cycle t: ctrl_writeEnable high in t+1; the register file captures it at the end of t+1.
- Coprocessor push at the edge ending cycle t: earliest grant in t+1, port write in t+2.
- cp_req_ready is low while count == FIFO_DEPTH, even if a pop occurs the same cycle (no push-on-full).
- A forced slot costs writeback exactly one cycle. The counter restarts at 0 after a forced pop.
- Worst-case coprocessor latency with continuous writeback: the head is written within STARVE_LIMIT+2 cycles of becoming head.
- Throughput: one register-file write per cycle maximum. Total FIFO drain with no writeback: FIFO_DEPTH cycles.

## Test plan
- Reset, then idle → all outputs 0, fifo_count = 0, cp_req_ready = 1, wb_ready = 1.
- wb_valid with reg 5, data 0xDEADBEEF at cycle t → one cycle later: enable = 1, reg = 5, data = 0xDEADBEEF. Separately, cp write of reg 0, data 0x1234 → popped, enable stays 0.
- Four cp pushes (regs 26–29, data 1–4) while wb_valid is held high → cp_req_ready drops at count 4. After 8 writeback wins, wb_ready = 0 for one cycle, reg 26 is written, and forced_slot pulses. The next forced slot writes reg 27 after another 8 writeback wins.
- FIFO full plus simultaneous pop in a writeback-idle cycle → push refused that cycle, count = 3; push accepted next cycle.
- cp push and wb_valid idle in the same cycle as a pop → count unchanged, order preserved (regs 10, 11, 12 written in push order).
- Assert ctrl_reset_n low with 3 entries buffered and enable high → outputs 0 immediately. After release, no buffered write is ever issued.
